pwm_timer: RTL and testbench
============================

// Module: pwm_timer
// PURPOSE
//   Memory-mapped multi-channel PWM timer. It is a slave on the PicoRV32 native memory bus, in the 0x8000_0600-0x8000_061F window.
//   Shared prescaler and period counter; per-channel compare sets duty. Period and duty writes are double-buffered and
//   applied at period wrap. The wrap event raises a level IRQ for the CPU; pwm_out is routed to the GPIO alternate functions.
// PARAMETERS
//   CHANNELS   4   number of PWM outputs, legal 1..4
//   CNT_WIDTH  16  width of prescaler, period, counter and duty registers, legal 8..16
// PORTS
//   clk       in   1         system clock (PLL clock domain)
//   reset     in   1         asynchronous, active-high reset
//   select    in   1         slave select from address decoder, held until ready
//   wstrb     in   4         byte write strobes; 0 = read
//   addr      in   5         byte address within window (addr[4:2] = word index)
//   data_i    in   32        write data
//   ready     out  1         single-cycle access acknowledge
//   data_o    out  32        read data, valid while ready=1
//   pwm_out   out  CHANNELS  PWM outputs
//   irq       out  1         level interrupt = WRAPF & IRQ_EN
// BEHAVIOUR
//   Register map (word offset):
//     0x00 CTRL: [0]=EN, [1]=IRQ_EN, other bits read 0.
//     0x04 PRESC.
//     0x08 PERIOD.
//     0x0C STATUS: [0]=WRAPF, write-1-to-clear.
//     0x10+4*i DUTYi, i < CHANNELS.
//     Unused offsets read 0 and ignore writes. Fields are CNT_WIDTH wide, zero-extended on read.
//   Reset: all registers, shadows, counters, WRAPF = 0; ready=0, data_o=0, pwm_out=0, irq=0.
//   Handshake:
//     - ready rises the cycle after select is seen with ready=0, and lasts exactly one cycle.
//     - ready is low while select is low. A select held past ready starts no new access until select drops.
//     - Write occurs on the edge that sets ready; only bytes with wstrb[b]=1 are updated.
//     - data_o is registered on the same edge and holds until the next access.
//   Counting, when EN=1:
//     - pc counts 0..PRESC. When pc==PRESC, pc<=0 and a tick occurs, so a tick comes every PRESC+1 clocks.
//     - On a tick: if cnt==PERIOD_S then cnt<=0 and wrap, else cnt<=cnt+1. The period is PERIOD_S+1 ticks.
//     - On wrap, PERIOD_S<=PERIOD and DUTYi_S<=DUTYi, and WRAPF is set.
//   Outputs:
//     - pwm_out[i] is registered: pwm_out[i] <= EN & (cnt < DUTYi_S). One clock latency from cnt.
//     - DUTY=0 gives constant low. DUTY>PERIOD gives constant high.
//     - PERIOD=0 wraps on every tick. cnt stays 0.
//   Disabled, EN=0:
//     - pc and cnt are held at 0 and pwm_out goes to 0 on the next edge.
//     - Shadows track the live registers every cycle, so enabling starts a fresh period with current values.
//   Write collisions:
//     - Writing PERIOD or DUTY while EN=1 has no effect until the next wrap.
//     - If a write of STATUS[0]=1 and a wrap happen in the same cycle, set wins and WRAPF stays 1.
//     - If a write clears EN in the same cycle as a wrap, WRAPF is still set.
//   Reset mid-operation clears everything immediately and asynchronously. An in-flight access is dropped and gets no ready.
// TESTING
//   1. Reset state:
//      - assert reset mid-count -> pwm_out=0, irq=0, ready=0 at once.
//      - after release, all registers read 0.
//   2. Basic PWM:
//      - PRESC=0, PERIOD=9, DUTY0=3, CTRL=1.
//      - expect pwm_out[0] high 3 of every 10 clocks, and WRAPF set every 10 clocks.
//   3. Prescaler and shadowing:
//      - PRESC=1, PERIOD=4; mid-period write DUTY1=2 (old value 5).
//      - expect old duty (constant high) to finish the period, then high 4 of every 10 clocks.
//   4. IRQ and collision:
//      - CTRL=3 -> irq rises at first wrap.
//      - writing STATUS=1 clears irq.
//      - a W1C timed on the wrap cycle leaves WRAPF=1.
//   5. Edge duties: PERIOD=7; DUTY0=0 -> always low; DUTY1=8 -> always high; PERIOD=0 with DUTY2=1 -> always high.
//   6. Bus: byte write wstrb=4'b0001 of 0xAB to PERIOD=0x1234 -> reads back 0x12AB.
//      - ready is one cycle per access.
//      - a held select produces no second ready.

Source files
------------

// File: rtl/pwm_timer.sv
// Multi-channel PWM timer on the PicoRV32 native bus: shared prescaler/period counter,
// per-channel compare, double-buffered period/duty applied at period wrap, level IRQ on wrap.
module pwm_timer #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                select,
    input  logic [3:0]          wstrb,
    input  logic [4:0]          addr,
    input  logic [31:0]         data_i,
    output logic                ready,
    output logic [31:0]         data_o,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                irq
);
    localparam int unsigned W = CNT_WIDTH;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_PRESC  = 3'd1;
    localparam logic [2:0] REG_PERIOD = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_ACK,
        BUS_HOLD
    } bus_state_t;

    bus_state_t bus_state, bus_state_nxt;
    logic       access;

    logic         en, en_nxt;
    logic         irq_en, irq_en_nxt;
    logic         wrapf, wrapf_nxt;
    logic [W-1:0] presc, presc_nxt;
    logic [W-1:0] period, period_nxt;
    logic [W-1:0] period_s, period_s_nxt;
    logic [W-1:0] pc, pc_nxt;
    logic [W-1:0] cnt, cnt_nxt;
    logic [W-1:0] duty [CHANNELS];
    logic [W-1:0] duty_nxt [CHANNELS];
    logic [W-1:0] duty_s [CHANNELS];
    logic [W-1:0] duty_s_nxt [CHANNELS];

    logic                tick;
    logic                wrap;
    logic                wr;
    logic [2:0]          word;
    logic [31:0]         wmask;
    logic [31:0]         rdata;
    logic [CHANNELS-1:0] pwm_nxt;
    logic                addr_unused;

    assign word        = addr[4:2];
    assign wr          = access && (wstrb != 4'b0000);
    assign wmask       = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    assign addr_unused = ^addr[1:0];

    // Byte-lane merge of a write into a CNT_WIDTH field; bytes above the field are dropped.
    function automatic logic [W-1:0] merge(input logic [W-1:0] old_val,
                                           input logic [31:0]  wdata,
                                           input logic [31:0]  mask);
        return W'((32'(old_val) & ~mask) | (wdata & mask));
    endfunction

    // Bus handshake state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_state <= BUS_IDLE;
        end else begin
            bus_state <= bus_state_nxt;
        end
    end

    // One access per select assertion; HOLD waits for select to drop
    always_comb begin
        bus_state_nxt = bus_state;
        access        = 1'b0;
        case (bus_state)
            BUS_IDLE: begin
                if (select) begin
                    bus_state_nxt = BUS_ACK;
                    access        = 1'b1;
                end
            end
            BUS_ACK:  bus_state_nxt = select ? BUS_HOLD : BUS_IDLE;
            BUS_HOLD: begin
                if (!select) begin
                    bus_state_nxt = BUS_IDLE;
                end
            end
            default:  bus_state_nxt = BUS_IDLE;
        endcase
    end

    // Counter, shadow and register next-state
    always_comb begin
        tick         = 1'b0;
        wrap         = 1'b0;
        en_nxt       = en;
        irq_en_nxt   = irq_en;
        wrapf_nxt    = wrapf;
        presc_nxt    = presc;
        period_nxt   = period;
        period_s_nxt = period_s;
        pc_nxt       = pc;
        cnt_nxt      = cnt;
        duty_nxt     = duty;
        duty_s_nxt   = duty_s;

        if (en) begin
            tick = (pc == presc);
            wrap = tick && (cnt == period_s);
            if (tick) begin
                pc_nxt  = '0;
                cnt_nxt = wrap ? '0 : cnt + W'(1);
            end else begin
                pc_nxt = pc + W'(1);
            end
            if (wrap) begin
                period_s_nxt = period;
                duty_s_nxt   = duty;
            end
        end else begin
            // Shadows follow the live registers so enabling starts with current values
            pc_nxt       = '0;
            cnt_nxt      = '0;
            period_s_nxt = period;
            duty_s_nxt   = duty;
        end

        if (wr) begin
            case (word)
                REG_CTRL: begin
                    if (wstrb[0]) begin
                        en_nxt     = data_i[0];
                        irq_en_nxt = data_i[1];
                    end
                end
                REG_PRESC:  presc_nxt  = merge(presc, data_i, wmask);
                REG_PERIOD: period_nxt = merge(period, data_i, wmask);
                REG_STATUS: begin
                    if (wstrb[0] && data_i[0]) begin
                        wrapf_nxt = 1'b0;
                    end
                end
                default: begin
                    for (int i = 0; i < int'(CHANNELS); i++) begin
                        if (addr[3:2] == 2'(i)) begin
                            duty_nxt[i] = merge(duty[i], data_i, wmask);
                        end
                    end
                end
            endcase
        end

        // A wrap in the same cycle as a W1C keeps the flag set
        if (wrap) begin
            wrapf_nxt = 1'b1;
        end
    end

    // Read mux; fields zero-extended, unmapped words read 0
    always_comb begin
        rdata = '0;
        case (word)
            REG_CTRL:   rdata = {30'd0, irq_en, en};
            REG_PRESC:  rdata = 32'(presc);
            REG_PERIOD: rdata = 32'(period);
            REG_STATUS: rdata = {31'd0, wrapf};
            default: begin
                for (int i = 0; i < int'(CHANNELS); i++) begin
                    if (addr[3:2] == 2'(i)) begin
                        rdata = 32'(duty[i]);
                    end
                end
            end
        endcase
    end

    always_comb begin
        pwm_nxt = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            pwm_nxt[i] = en && (cnt < duty_s[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en       <= 1'b0;
            irq_en   <= 1'b0;
            wrapf    <= 1'b0;
            presc    <= '0;
            period   <= '0;
            period_s <= '0;
            pc       <= '0;
            cnt      <= '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                duty[i]   <= '0;
                duty_s[i] <= '0;
            end
        end else begin
            en       <= en_nxt;
            irq_en   <= irq_en_nxt;
            wrapf    <= wrapf_nxt;
            presc    <= presc_nxt;
            period   <= period_nxt;
            period_s <= period_s_nxt;
            pc       <= pc_nxt;
            cnt      <= cnt_nxt;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                duty[i]   <= duty_nxt[i];
                duty_s[i] <= duty_s_nxt[i];
            end
        end
    end

    // Registered outputs; irq tracks the flag and enable as they will be after this edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready   <= 1'b0;
            data_o  <= '0;
            pwm_out <= '0;
            irq     <= 1'b0;
        end else begin
            ready   <= access;
            if (access) begin
                data_o <= rdata;
            end
            pwm_out <= pwm_nxt;
            irq     <= wrapf_nxt && irq_en_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_timer.sv
// Self-checking bench for pwm_timer: register table, directed PWM/IRQ corner cases and
// randomized traffic against a period-level reference model.
module tb_pwm_timer;
    logic        clk = 1'b0;
    logic        reset;
    logic        select;
    logic [3:0]  wstrb;
    logic [4:0]  addr;
    logic [31:0] data_i;
    logic        ready;
    logic [31:0] data_o;
    logic [3:0]  pwm_out;
    logic        irq;

    pwm_timer #(.CHANNELS(4), .CNT_WIDTH(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .select (select),
        .wstrb  (wstrb),
        .addr   (addr),
        .data_i (data_i),
        .ready  (ready),
        .data_o (data_o),
        .pwm_out(pwm_out),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: live registers, values in force for the current period, period start edge
    int unsigned m_presc, m_period, m_per_s;
    int unsigned m_duty [4];
    int unsigned m_duty_s [4];
    bit          m_en, m_irq_en, m_wrapf, m_irq;
    bit [3:0]    m_pwm, m_hn;
    int          m_n, m_start;
    logic [31:0] m_rdata;
    logic [3:0]  trace [1024];

    typedef struct {
        logic [3:0]  ws;
        logic [4:0]  a;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned merge16(input int unsigned old, input logic [3:0] ws,
                                            input logic [31:0] d);
        logic [31:0] m;
        m = {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};
        return (old & ~m | d & m) & 32'hFFFF;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a[4:2])
            3'd0:    return {30'd0, m_irq_en, m_en};
            3'd1:    return m_presc;
            3'd2:    return m_period;
            3'd3:    return {31'd0, m_wrapf};
            default: return m_duty[a[3:2]];
        endcase
    endfunction

    // Period length in clocks for the values currently in force
    function automatic int lcur();
        return int'((m_presc + 1) * (m_per_s + 1));
    endfunction

    task automatic m_reset();
        m_presc = 0; m_period = 0; m_per_s = 0;
        for (int i = 0; i < 4; i++) begin
            m_duty[i] = 0;
            m_duty_s[i] = 0;
        end
        m_en = 0; m_irq_en = 0; m_wrapf = 0; m_irq = 0;
        m_pwm = '0; m_hn = '0; m_n = 0; m_start = 0; m_rdata = '0;
    endtask

    // Advance the model by one clock edge, given the bus inputs presented at that edge
    task automatic model_edge(input bit acc);
        bit wrap;
        int j;
        m_n++;
        if (acc) m_rdata = model_read(addr);
        wrap = 0;
        if (m_en) begin
            if (m_n - m_start == lcur()) begin
                wrap = 1;
                m_start = m_n;
                m_per_s = m_period;
                m_duty_s = m_duty;
            end
        end else begin
            m_start = m_n;
            m_per_s = m_period;
            m_duty_s = m_duty;
        end
        if (acc && wstrb != 4'h0) begin
            case (addr[4:2])
                3'd0: if (wstrb[0]) begin
                    m_en = data_i[0];
                    m_irq_en = data_i[1];
                end
                3'd1: m_presc = merge16(m_presc, wstrb, data_i);
                3'd2: m_period = merge16(m_period, wstrb, data_i);
                3'd3: if (wstrb[0] && data_i[0]) m_wrapf = 0;
                default: m_duty[addr[3:2]] = merge16(m_duty[addr[3:2]], wstrb, data_i);
            endcase
        end
        if (wrap) m_wrapf = 1;
        m_pwm = m_hn;
        j = m_n - m_start;
        for (int i = 0; i < 4; i++)
            m_hn[i] = m_en && (j < int'((m_presc + 1) * m_duty_s[i]));
        m_irq = m_wrapf && m_irq_en;
    endtask

    task automatic tick_edge(input bit acc);
        @(posedge clk);
        model_edge(acc);
        #1;
        trace[m_n & 1023] = pwm_out;
        chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
        chk("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic bus_access(input logic [3:0] ws, input logic [4:0] a, input logic [31:0] d,
                              output logic [31:0] rd);
        select = 1'b1; wstrb = ws; addr = a; data_i = d;
        tick_edge(1);
        chk("ready_ack", 32'(ready), 32'd1);
        chk("data_o", data_o, m_rdata);
        rd = data_o;
        select = 1'b0; wstrb = 4'h0; data_i = '0;
        tick_edge(0);
        chk("ready_drop", 32'(ready), 32'd0);
        chk("data_hold", data_o, m_rdata);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        logic [31:0] rd;
        bus_access(4'hF, a, d, rd);
    endtask

    task automatic rd_reg(input logic [4:0] a, output logic [31:0] rd);
        bus_access(4'h0, a, 32'd0, rd);
    endtask

    function automatic int count_hi(input int ch, input int from_e, input int to_e);
        int c = 0;
        for (int e = from_e; e <= to_e; e++) c += int'(trace[e & 1023][ch]);
        return c;
    endfunction

    // Idle until the next access edge coincides with a period wrap
    task automatic wait_pre_wrap();
        int k = 0;
        while ((m_n + 1 != m_start + lcur()) && k < 300) begin
            tick_edge(0);
            k++;
        end
        chk("wrap_align_bound", 32'(k < 300), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [13];
        logic [31:0] rd;
        int          e0, k, rdy;

        reset = 1'b1; select = 1'b0; wstrb = 4'h0; addr = '0; data_i = '0;
        m_reset();
        #12;
        reset = 1'b0;
        chk("reset_pwm", 32'(pwm_out), 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_data_o", data_o, 32'd0);

        // Register access table: write (if strobed), then read back
        vecs[0]  = '{4'hF, 5'h08, 32'h0000_1234, 32'h0000_1234};
        vecs[1]  = '{4'h1, 5'h08, 32'h0000_00AB, 32'h0000_12AB};
        vecs[2]  = '{4'h2, 5'h08, 32'h0000_CD00, 32'h0000_CDAB};
        vecs[3]  = '{4'hC, 5'h08, 32'hFFFF_FFFF, 32'h0000_CDAB};
        vecs[4]  = '{4'hF, 5'h04, 32'hFFFF_FFFF, 32'h0000_FFFF};
        vecs[5]  = '{4'h0, 5'h04, 32'h0000_0000, 32'h0000_FFFF};
        vecs[6]  = '{4'hF, 5'h00, 32'hFFFF_FFFE, 32'h0000_0002};
        vecs[7]  = '{4'h2, 5'h00, 32'hFFFF_FFFF, 32'h0000_0002};
        vecs[8]  = '{4'hF, 5'h00, 32'h0000_0000, 32'h0000_0000};
        vecs[9]  = '{4'hF, 5'h1C, 32'h0005_5AA5, 32'h0000_5AA5};
        vecs[10] = '{4'h3, 5'h10, 32'h1234_5678, 32'h0000_5678};
        vecs[11] = '{4'hF, 5'h0C, 32'h0000_0001, 32'h0000_0000};
        vecs[12] = '{4'hF, 5'h0A, 32'h0000_0042, 32'h0000_0042};
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].ws != 4'h0) bus_access(vecs[i].ws, vecs[i].a, vecs[i].wd, rd);
            rd_reg(vecs[i].a, rd);
            chk($sformatf("reg_vec%0d", i), rd, vecs[i].exp);
        end

        // Basic PWM: 3 high of every 10 clocks
        wr(5'h04, 0); wr(5'h08, 9); wr(5'h10, 3); wr(5'h00, 1);
        e0 = m_n - 1;
        repeat (19) tick_edge(0);
        chk("basic_hi_p1", 32'(count_hi(0, e0 + 1, e0 + 10)), 32'd3);
        chk("basic_hi_p2", 32'(count_hi(0, e0 + 11, e0 + 20)), 32'd3);
        rd_reg(5'h0C, rd);
        chk("basic_wrapf", rd, 32'd1);
        wr(5'h00, 0); wr(5'h0C, 1);

        // Prescaler and shadowing: old duty (constant high) finishes the period
        wr(5'h04, 1); wr(5'h08, 4); wr(5'h14, 5); wr(5'h00, 1);
        e0 = m_n - 1;
        repeat (2) tick_edge(0);
        wr(5'h14, 2);
        while (m_n < e0 + 30) tick_edge(0);
        chk("shadow_old_period", 32'(count_hi(1, e0 + 1, e0 + 10)), 32'd10);
        chk("shadow_new_p2", 32'(count_hi(1, e0 + 11, e0 + 20)), 32'd4);
        chk("shadow_new_p3", 32'(count_hi(1, e0 + 21, e0 + 30)), 32'd4);
        wr(5'h00, 0); wr(5'h0C, 1);

        // IRQ at first wrap, W1C, collisions with the wrap edge
        wr(5'h04, 1); wr(5'h08, 9); wr(5'h10, 3); wr(5'h00, 3);
        e0 = m_n - 1;
        k = 0;
        while (!irq && k < 100) begin
            tick_edge(0);
            k++;
        end
        chk("irq_first_wrap", 32'(m_n - e0), 32'd20);
        wr(5'h0C, 1);
        chk("irq_w1c", 32'(irq), 32'd0);
        wait_pre_wrap();
        wr(5'h0C, 1);
        chk("irq_w1c_on_wrap", 32'(irq), 32'd1);
        rd_reg(5'h0C, rd);
        chk("wrapf_w1c_on_wrap", rd, 32'd1);
        wr(5'h0C, 1);
        wait_pre_wrap();
        wr(5'h00, 2);
        rd_reg(5'h0C, rd);
        chk("wrapf_en_clear_on_wrap", rd, 32'd1);
        wr(5'h0C, 1); wr(5'h00, 0);

        // Edge duties
        wr(5'h08, 7); wr(5'h04, 0); wr(5'h10, 0); wr(5'h14, 8); wr(5'h00, 1);
        e0 = m_n - 1;
        repeat (15) tick_edge(0);
        chk("duty0_always_low", 32'(count_hi(0, e0 + 1, e0 + 16)), 32'd0);
        chk("duty_gt_period_high", 32'(count_hi(1, e0 + 1, e0 + 16)), 32'd16);
        wr(5'h00, 0); wr(5'h08, 0); wr(5'h18, 1); wr(5'h00, 1);
        e0 = m_n - 1;
        repeat (15) tick_edge(0);
        chk("period0_duty1_high", 32'(count_hi(2, e0 + 1, e0 + 16)), 32'd16);
        rd_reg(5'h0C, rd);
        chk("period0_wrapf", rd, 32'd1);
        wr(5'h00, 0); wr(5'h0C, 1);

        // Randomized traffic against the model
        for (int r = 0; r < 6; r++) begin
            wr(5'h00, 0); wr(5'h0C, 1);
            wr(5'h04, $urandom_range(0, 3));
            wr(5'h08, $urandom_range(0, 7));
            for (int ch = 0; ch < 4; ch++) wr(5'(16 + 4 * ch), $urandom_range(0, 10));
            wr(5'h00, {30'd0, 1'($urandom_range(0, 1)), 1'b1});
            repeat (60) begin
                k = int'($urandom_range(0, 19));
                if (k < 2)
                    bus_access(4'($urandom_range(1, 15)), 5'(16 + 4 * $urandom_range(0, 3)),
                               $urandom_range(0, 10), rd);
                else if (k == 2) wr(5'h08, $urandom_range(0, 7));
                else if (k == 3) wr(5'h0C, 1);
                else if (k < 6) rd_reg(5'(4 * $urandom_range(0, 7)), rd);
                else tick_edge(0);
            end
        end
        wr(5'h00, 0);

        // Held select gets exactly one ready
        select = 1'b1; wstrb = 4'h0; addr = 5'h08; data_i = '0;
        tick_edge(1);
        rdy = int'(ready);
        repeat (4) begin
            tick_edge(0);
            rdy += int'(ready);
        end
        select = 1'b0;
        tick_edge(0);
        chk("held_select_readies", 32'(rdy), 32'd1);

        // Asynchronous reset mid-count and during an access
        wr(5'h04, 0); wr(5'h08, 9); wr(5'h10, 5); wr(5'h00, 3);
        repeat (25) tick_edge(0);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_pwm", 32'(pwm_out), 32'd0);
        chk("rst_async_irq", 32'(irq), 32'd0);
        chk("rst_async_ready", 32'(ready), 32'd0);
        select = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_access_dropped", 32'(ready), 32'd0);
        reset = 1'b0;
        select = 1'b0;
        m_reset();
        for (int w = 0; w < 8; w++) begin
            rd_reg(5'(4 * w), rd);
            chk($sformatf("post_reset_reg%0d", w), rd, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
